vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL take parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL take parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL take parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 The block SHALL take parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL take parameters V_ACTIVE 480, V_FP 10, V_SYNC 2 and V_BP 33, meaning the vertical equivalents in lines.
REQ-006 The block SHALL provide port vga_clk, input, 1 bit, the pixel-domain clock; there is one clock.
REQ-007 The block SHALL provide port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-008 The block SHALL provide port pix_en, input, 1 bit, the pixel-advance enable (tie high at 25 MHz; pulse every 2nd cycle from 50 MHz).
REQ-009 The block SHALL provide ports DrawX and DrawY, output, 10 bits each, the current horizontal and vertical count.
REQ-010 The block SHALL provide port blank, output, 1 bit, high only inside the visible area (1 = draw pixel).
REQ-011 The block SHALL provide ports hs and vs, output, 1 bit each, active-low horizontal and vertical sync.
REQ-012 The block SHALL provide port frame_start, output, 1 bit, a pulse while DrawX=0 and DrawY=0 are presented.

Function
REQ-013 The block SHALL hold hcnt in 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-014 The block SHALL hold vcnt in 0..V_TOTAL-1, where V_TOTAL is the vertical sum (525).
REQ-015 On a vga_clk edge with pix_en=1, hcnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcnt SHALL increment in the same edge.
REQ-016 When hcnt wraps with vcnt=V_TOTAL-1, both counters SHALL wrap to 0 in the same edge.
REQ-017 With pix_en=0, counters and all outputs SHALL hold their values, and frame_start SHALL be forced to 0.
REQ-018 Each output SHALL be a register loaded from the pre-increment counter decode, giving one pix_en-qualified cycle of latency so that DrawX, DrawY, blank, hs and vs are mutually coherent.
REQ-019 The decode SHALL set DrawX=hcnt and DrawY=vcnt.
REQ-020 The decode SHALL set blank=(hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
REQ-021 The decode SHALL drive hs low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751.
REQ-022 The decode SHALL drive vs low for vcnt in [490, 491] by the equivalent rule.
REQ-023 frame_start SHALL be high for exactly one pix_en-qualified cycle per frame.
REQ-024 Counter comparisons SHALL be 10-bit unsigned; parameter sums exceeding 1023 are illegal and SHALL fail elaboration.
REQ-025 Each axis SHALL run a four-state machine ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with transitions at its region boundaries.
REQ-026 The hs/vs/blank decode SHALL equal the state-based decode; this is asserted in simulation.

Reset
REQ-027 While reset_n=0, hcnt, vcnt, DrawX and DrawY SHALL be 0, hs and vs SHALL be 1, blank SHALL be 0 and frame_start SHALL be 0, with both state machines in ACTIVE.
REQ-028 Reset assertion mid-line or mid-frame SHALL take effect immediately and asynchronously.
REQ-029 Deassertion SHALL be synchronised by the caller.
REQ-030 The first pix_en edge after release SHALL present DrawX=0, DrawY=0, blank=1 and frame_start=1.

Configuration
REQ-031 With VGA_FRAME_CNT_EN defined, the block SHALL add output frame_count (16 bits, reset 0), incremented in the cycle frame_start is asserted, wrapping 65535->0.
REQ-032 Without VGA_FRAME_CNT_EN, the frame_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the default timing constants, the H_TOTAL/V_TOTAL derivations and the axis-state enum (ACTIVE, FRONT, SYNC, BACK).
REQ-034 The block SHALL instantiate sub-module vga_axis_counter twice, one per axis.
REQ-035 vga_axis_counter SHALL take inputs clk, reset_n, adv and parameters ACTIVE, FP, SYNC and BP.
REQ-036 vga_axis_counter SHALL output count, state, sync_n, active and wrap.
REQ-037 The horizontal wrap output, ANDed with pix_en, SHALL drive the vertical adv input.

Verification
REQ-038 With pix_en=1, reset released and 800 cycles run, the bench SHALL see DrawX 0..799 once each, DrawY=0, then DrawX=0, DrawY=1 on cycle 801.
REQ-039 Over one line, the bench SHALL see hs low for exactly cycles DrawX=656..751 (96 cycles) and blank high exactly for DrawX=0..639 on line 0.
REQ-040 Over a full frame (420000 cycles), the bench SHALL see vs low only on DrawY=490..491, frame_start asserted exactly twice (cycle 1 and cycle 420001), and DrawY never exceeding 524.
REQ-041 With pix_en toggling 1,0,1,0, the bench SHALL see outputs change only after pix_en=1 edges, one line taking 1600 clocks and frame_start high for 1 clock.
REQ-042 With reset_n pulled low at DrawX=300, DrawY=200, the bench SHALL see outputs at reset values immediately, then DrawX=0, DrawY=0, frame_start=1 after release.
REQ-043 With VGA_FRAME_CNT_EN defined and 3 frames run, the bench SHALL see frame_count=3.
REQ-044 With VGA_FRAME_CNT_EN defined and frame_count preloaded to 65535 via force, the bench SHALL see frame_count=0 at the next frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, axis-state encoding and helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Region a count falls in, used to cross-check the state machines.
  function automatic axis_state_e axis_region(input logic [CNT_W-1:0] count, input int active,
                                              input int fp, input int sync);
    int c;
    c = int'(count);
    if (c < active)             return ST_ACTIVE;
    if (c < active + fp)        return ST_FRONT;
    if (c < active + fp + sync) return ST_SYNC;
    return ST_BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK region machine.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output axis_state_e      state,
  output logic             sync_n,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > CNT_MAX) begin : g_total_too_wide
    $error("vga_axis_counter: ACTIVE+FP+SYNC+BP exceeds the 10-bit counter range");
  end
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_empty_region
    $error("vga_axis_counter: every timing region must be at least one unit wide");
  end

  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(TOTAL - 1);

  axis_state_e state_nxt;

  assign wrap = (count == LAST_COUNT);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACTIVE: if (count == LAST_ACTIVE) state_nxt = ST_FRONT;
      ST_FRONT:  if (count == LAST_FRONT)  state_nxt = ST_SYNC;
      ST_SYNC:   if (count == LAST_SYNC)   state_nxt = ST_BACK;
      ST_BACK:   if (wrap)                 state_nxt = ST_ACTIVE;
      default:                             state_nxt = ST_ACTIVE;
    endcase
  end

  // NOTE: non-blocking assignments make count and state both update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      state <= ST_ACTIVE;
    end else if (adv) begin
      count <= wrap ? '0 : count + CNT_W'(1);
      state <= state_nxt;
    end
  end

  assign sync_n = (state != ST_SYNC);
  assign active = (state == ST_ACTIVE);

`ifndef SYNTHESIS
  a_region_match: assert property (@(posedge clk) disable iff (!reset_n)
    state == axis_region(count, ACTIVE, FP, SYNC))
    else $error("vga_axis_counter: state disagrees with count region");
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: registered DrawX/DrawY, blank, hs/vs and frame_start from two axis counters.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             hs,
  output logic             vs,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] hcnt, vcnt;
  axis_state_e      h_state, v_state;
  logic             h_sync_n, v_sync_n, h_active, v_active, h_wrap, v_wrap;
  logic             v_adv;
  logic             blank_d, hs_d, vs_d, first_d;

  // The vertical axis steps only on the pixel that ends a line.
  assign v_adv = h_wrap & pix_en;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .adv     (pix_en),
    .count   (hcnt),
    .state   (h_state),
    .sync_n  (h_sync_n),
    .active  (h_active),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .adv     (v_adv),
    .count   (vcnt),
    .state   (v_state),
    .sync_n  (v_sync_n),
    .active  (v_active),
    .wrap    (v_wrap)
  );

  // Decode from the pre-increment counts; registering it keeps all outputs on the same pixel.
  assign blank_d = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
  assign hs_d    = !((hcnt >= HS_START) && (hcnt <= HS_END));
  assign vs_d    = !((vcnt >= VS_START) && (vcnt <= VS_END));
  assign first_d = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && first_d;
      if (pix_en) begin
        DrawX <= hcnt;
        DrawY <= vcnt;
        blank <= blank_d;
        hs    <= hs_d;
        vs    <= vs_d;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (pix_en && first_d) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_decode_match: assert property (@(posedge vga_clk) disable iff (!reset_n)
    (blank_d == (h_active && v_active)) && (hs_d == h_sync_n) && (vs_d == v_sync_n))
    else $error("vga_timing_gen: counter decode disagrees with state decode");

  a_wrap_in_back: assert property (@(posedge vga_clk) disable iff (!reset_n)
    (!h_wrap || h_state == ST_BACK) && (!v_wrap || v_state == ST_BACK) &&
    (v_wrap == (vcnt == V_LAST)))
    else $error("vga_timing_gen: axis wrap outside back porch");
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance plus a small-timing instance for frame-level runs.
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en  = 1'b0;

  logic [9:0] draw_x, draw_y;
  logic       blank, hs, vs, frame_start;
  logic [9:0] s_draw_x, s_draw_y;
  logic       s_blank, s_hs, s_vs, s_frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count, s_frame_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // Small timing: line = 25 pixels (hs low 18..21), frame = 19 lines (vs low 14..15).
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut_s (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .DrawX       (s_draw_x),
    .DrawY       (s_draw_y),
    .blank       (s_blank),
    .hs          (s_hs),
    .vs          (s_vs),
    .frame_start (s_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count (s_frame_count)
`endif
  );

  function automatic logic [23:0] pk(input int x, input int y, input bit b, input bit h,
                                     input bit v, input bit f);
    return {10'(x), 10'(y), b, h, v, f};
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic apply_reset();
    pix_en  = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] exp_v;
    reset_n = 1'b0;
    pix_en  = 1'b1;
    repeat (3) step();
    exp_v = pk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
      failures++;
      $display("FAIL reset_default got=%h exp=%h", {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
    end
    checks++;
    if ({s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start} !== exp_v) begin
      failures++;
      $display("FAIL reset_small got=%h exp=%h", {s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start}, exp_v);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame_count got=%0d exp=0", frame_count);
    end
`endif
    reset_n = 1'b1;
    step();
    exp_v = pk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
      failures++;
      $display("FAIL first_pixel got=%h exp=%h", {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
    end
  endtask

  task automatic test_line();
    logic [23:0] exp_v;
    int hs_low, blank_hi;
    hs_low   = 0;
    blank_hi = 0;
    apply_reset();
    pix_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step();
      exp_v = pk(c, 0, c < 640, !(c >= 656 && c <= 751), 1'b1, c == 0);
      checks++;
      if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
        failures++;
        $display("FAIL line0 c=%0d got=%h exp=%h", c, {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
      end
      if (hs === 1'b0) hs_low++;
      if (blank === 1'b1) blank_hi++;
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL hs_low_count got=%0d exp=96", hs_low);
    end
    checks++;
    if (blank_hi != 640) begin
      failures++;
      $display("FAIL blank_high_count got=%0d exp=640", blank_hi);
    end
    step();
    exp_v = pk(0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
      failures++;
      $display("FAIL line1_start got=%h exp=%h", {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
    end
  endtask

  task automatic test_pix_en_toggle();
    logic [23:0] exp_v;
    int n_adv, fs_hi, x, y;
    n_adv = 0;
    fs_hi = 0;
    apply_reset();
    for (int k = 0; k < 1602; k++) begin
      pix_en = (k % 2 == 0);
      step();
      if (pix_en) n_adv++;
      x = (n_adv - 1) % 800;
      y = (n_adv - 1) / 800;
      exp_v = pk(x, y, (x < 640) && (y < 480), !(x >= 656 && x <= 751), 1'b1,
                 pix_en && (n_adv == 1));
      checks++;
      if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
        failures++;
        $display("FAIL toggle k=%0d got=%h exp=%h", k, {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
      end
      if (frame_start === 1'b1) fs_hi++;
    end
    checks++;
    if (fs_hi != 1) begin
      failures++;
      $display("FAIL toggle_frame_start_clocks got=%0d exp=1", fs_hi);
    end
    pix_en = 1'b1;
  endtask

  task automatic test_frame();
    logic [23:0] exp_v;
    int x, y, fs_hi, fs_second, vs_lo, max_y;
    fs_hi     = 0;
    fs_second = -1;
    vs_lo     = 0;
    max_y     = 0;
    apply_reset();
    pix_en = 1'b1;
    for (int c = 0; c < 476; c++) begin
      step();
      x = c % 25;
      y = (c / 25) % 19;
      exp_v = pk(x, y, (x < 16) && (y < 12), !(x >= 18 && x <= 21), !(y >= 14 && y <= 15),
                 (x == 0) && (y == 0));
      checks++;
      if ({s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start} !== exp_v) begin
        failures++;
        $display("FAIL frame c=%0d got=%h exp=%h", c, {s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start}, exp_v);
      end
      if (s_frame_start === 1'b1) begin
        fs_hi++;
        if (c != 0) fs_second = c;
      end
      if (s_vs === 1'b0) vs_lo++;
      if (int'(s_draw_y) > max_y) max_y = int'(s_draw_y);
    end
    checks++;
    if (fs_hi != 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_hi);
    end
    checks++;
    if (fs_second != 475) begin
      failures++;
      $display("FAIL frame_start_second_cycle got=%0d exp=475", fs_second);
    end
    checks++;
    if (vs_lo != 50) begin
      failures++;
      $display("FAIL vs_low_count got=%0d exp=50", vs_lo);
    end
    checks++;
    if (max_y != 18) begin
      failures++;
      $display("FAIL max_draw_y got=%0d exp=18", max_y);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp_v;
    apply_reset();
    pix_en = 1'b1;
    repeat (186) step();
    checks++;
    if ({s_draw_x, s_draw_y} !== {10'd10, 10'd7}) begin
      failures++;
      $display("FAIL mid_position got=%0d,%0d exp=10,7", s_draw_x, s_draw_y);
    end
    #3;
    reset_n = 1'b0;
    #1;
    exp_v = pk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start} !== exp_v) begin
      failures++;
      $display("FAIL async_reset_small got=%h exp=%h", {s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start}, exp_v);
    end
    checks++;
    if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
      failures++;
      $display("FAIL async_reset_default got=%h exp=%h", {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    exp_v = pk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start} !== exp_v) begin
      failures++;
      $display("FAIL after_release_small got=%h exp=%h", {s_draw_x, s_draw_y, s_blank, s_hs, s_vs, s_frame_start}, exp_v);
    end
    checks++;
    if ({draw_x, draw_y, blank, hs, vs, frame_start} !== exp_v) begin
      failures++;
      $display("FAIL after_release_default got=%h exp=%h", {draw_x, draw_y, blank, hs, vs, frame_start}, exp_v);
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_count();
    apply_reset();
    pix_en = 1'b1;
    step();
    checks++;
    if (s_frame_count !== 16'd1) begin
      failures++;
      $display("FAIL frame_count_first got=%0d exp=1", s_frame_count);
    end
    repeat (950) step();
    checks++;
    if (s_frame_count !== 16'd3 || s_frame_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_count_three got=%0d fs=%b exp=3 fs=1", s_frame_count, s_frame_start);
    end
    repeat (10) step();
    force dut_s.frame_count = 16'hFFFF;
    #1;
    release dut_s.frame_count;
    step();
    checks++;
    if (s_frame_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL frame_count_preload got=%0d exp=65535", s_frame_count);
    end
    repeat (464) step();
    checks++;
    if (s_frame_count !== 16'd0 || s_frame_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_count_wrap got=%0d fs=%b exp=0 fs=1", s_frame_count, s_frame_start);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_pix_en_toggle();
    test_frame();
    test_reset_mid();
`ifdef VGA_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
